// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: streams sequential ROM words into a small FIFO
// tagged with their byte PC, hands them to fetch and redirects on flush.
module instr_prefetch #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  flush,
  input  logic [31:0]           flush_target,
  input  logic                  instr_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]           fetch_pc_r;
  logic [31:0]           req_pc_r;
  logic                  inflight_r;
  logic [CNT_W-1:0]      count_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [DATA_WIDTH-1:0] fifo_instr_r [DEPTH];
  logic [31:0]           fifo_pc_r [DEPTH];

  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CNT_W-1:0]      occupancy_s;

  // The ROM samples the live fetch address, so its data next cycle belongs to req_pc_r.
  assign rom_address = fetch_pc_r[ADDR_WIDTH+1:2];
  assign instr_valid = (count_r != {CNT_W{1'b0}});

  // Handshake decode; flush suppresses issue, push and pop alike
  always_comb begin
    occupancy_s = count_r + CNT_W'(inflight_r);
    issue_s     = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (flush) begin
      issue_s = 1'b0;
      push_s  = 1'b0;
      pop_s   = 1'b0;
    end else begin
      issue_s = (occupancy_s < DEPTH_C);
      push_s  = inflight_r;
      pop_s   = instr_valid & instr_ready;
    end
  end

  // Fetch address and the single outstanding ROM request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r <= 32'h0000_0000;
      req_pc_r   <= 32'h0000_0000;
      inflight_r <= 1'b0;
    end else if (flush) begin
      fetch_pc_r <= flush_target & 32'hFFFF_FFFC;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        req_pc_r   <= fetch_pc_r;
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
    end
  end

  // FIFO occupancy and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r  <= {CNT_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (flush) begin
      count_r  <= {CNT_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: instruction word with its byte PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_r[i] <= {DATA_WIDTH{1'b0}};
        fifo_pc_r[i]    <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_instr_r[wr_ptr_r] <= rom_data;
      fifo_pc_r[wr_ptr_r]    <= req_pc_r;
    end
  end

  // Head presentation, forced to zero when empty
  always_comb begin
    if (instr_valid) begin
      instr = fifo_instr_r[rd_ptr_r];
      pc    = fifo_pc_r[rd_ptr_r];
    end else begin
      instr = {DATA_WIDTH{1'b0}};
      pc    = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed scenarios plus randomized ready/flush traffic,
// checked by a stream scoreboard (sequential PCs restarting at each redirect).
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_address;
  logic [31:0] rom_data = 32'h0;
  logic        flush;
  logic [31:0] flush_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;
  int gap = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  instr_prefetch #(.DEPTH(4), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rom_address(rom_address), .rom_data(rom_data),
    .flush(flush), .flush_target(flush_target), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr(instr), .pc(pc)
  );

  always #5 clk = ~clk;

  // ROM[i] = 0x1000_0000 + i, indexed by byte PC modulo 256 words
  function automatic logic [31:0] rom_word(input logic [31:0] byte_pc);
    return 32'h1000_0000 + {24'h0, byte_pc[9:2]};
  endfunction

  always @(posedge clk) rom_data <= rom_word({22'h0, rom_address, 2'b00});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!instr_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_timeout"}, {31'h0, instr_valid}, 32'h1);
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  // Scoreboard monitor: every accepted head must be the next PC of the current stream
  always @(negedge clk) begin
    if (!rst) begin
      sb_restart(32'h0);
      gap = 0;
    end else if (flush) begin
      sb_restart(flush_target & 32'hFFFF_FFFC);
      gap = 0;
    end else begin
      if (instr_valid && instr_ready) begin
        exp_pc = exp_q.pop_front();
        chk("sb_pc", pc, exp_pc);
        chk("sb_instr", instr, rom_word(exp_pc));
        exp_q.push_back(exp_q[$] + 32'd4);
      end
      if (!instr_valid) begin
        gap++;
        chk("empty_instr", instr, 32'h0);
        chk("empty_pc", pc, 32'h0);
      end else begin
        gap = 0;
      end
      chk("no_stall", {31'h0, gap > 6}, 32'h0);
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; flush_target = 32'h0; instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_rom_addr", {24'h0, rom_address}, 32'h0);

    // Release: first word visible two cycles later, then one per cycle
    step(); rst = 1'b1;
    @(negedge clk); chk("lat_c0", {31'h0, instr_valid}, 32'h0);
    @(negedge clk); chk("lat_c1", {31'h0, instr_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stream_valid", {31'h0, instr_valid}, 32'h1);
      chk("stream_pc", pc, 32'(i * 4));
      chk("stream_instr", instr, 32'h1000_0000 + 32'(i));
    end

    // Saturate with ready low, then drain without gaps
    step(); flush = 1'b1; flush_target = 32'h0; instr_ready = 1'b0;
    step(); flush = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("full_valid", {31'h0, instr_valid}, 32'h1);
    chk("full_head_pc", pc, 32'h0);
    step(); instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_valid", {31'h0, instr_valid}, 32'h1);
      chk("drain_pc", pc, 32'(i * 4));
    end

    // Flush while full and while popping; target bits [1:0] dropped
    step(); instr_ready = 1'b0; flush = 1'b1; flush_target = 32'h0;
    step(); flush = 1'b0;
    repeat (10) step();
    step(); flush = 1'b1; flush_target = 32'h43; instr_ready = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk); chk("flush_valid_low", {31'h0, instr_valid}, 32'h0);
    wait_valid("flush43");
    chk("flush43_pc", pc, 32'h40);
    chk("flush43_instr", instr, 32'h1000_0010);

    // Back-to-back flushes: the second wins
    step(); flush = 1'b1; flush_target = 32'h20;
    step(); flush_target = 32'h80;
    step(); flush = 1'b0;
    wait_valid("flush80");
    chk("flush80_pc", pc, 32'h80);

    // ROM address wrap
    step(); flush = 1'b1; flush_target = 32'h3F8;
    step(); flush = 1'b0;
    @(negedge clk); chk("wrap_addr0", {24'h0, rom_address}, 32'hFE);
    @(negedge clk); chk("wrap_addr1", {24'h0, rom_address}, 32'hFF);
    @(negedge clk); chk("wrap_addr2", {24'h0, rom_address}, 32'h00);
    chk("wrap_pc0", pc, 32'h3F8);
    @(negedge clk); chk("wrap_pc1", pc, 32'h3FC);
    @(negedge clk); chk("wrap_pc2", pc, 32'h400);
    chk("wrap_instr2", instr, 32'h1000_0000);

    // Async reset with count=3 and one request in flight
    step(); instr_ready = 1'b0; flush = 1'b1; flush_target = 32'h0;
    step(); flush = 1'b0;
    repeat (4) step();
    chk("pre_rst_valid", {31'h0, instr_valid}, 32'h1);
    rst = 1'b0;
    #1;
    chk("async_valid", {31'h0, instr_valid}, 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_pc", pc, 32'h0);
    chk("async_rom_addr", {24'h0, rom_address}, 32'h0);
    repeat (2) step();
    rst = 1'b1; instr_ready = 1'b1;
    wait_valid("restart");
    chk("restart_pc", pc, 32'h0);
    chk("restart_instr", instr, 32'h1000_0000);

    // Randomized ready and redirects
    repeat (3000) begin
      step();
      instr_ready  = ($urandom_range(0, 99) < 70);
      flush        = ($urandom_range(0, 99) < 4);
      flush_target = $urandom;
    end
    step(); flush = 1'b0; instr_ready = 1'b1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
